// File: rtl/keypad_direction_filter.sv
// ============================================================================
//  Module   : keypad_direction_filter
//  Brief    : Scan-code pulses to a frame-aligned numpad held-key vector with
//             last-pressed-wins direction resolution. KEY_STUCK_TIMEOUT_EN
//             compiles in per-key stuck timeout counters.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module keypad_direction_filter #(
   parameter int unsigned STUCK_FRAMES = 30
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       startOfFrame,
   input  logic [8:0] keyCode,
   input  logic       make,
   input  logic       brakee,
   input  logic       game_over,
   output logic [9:0] num_input
);

   if (STUCK_FRAMES < 1 || STUCK_FRAMES > 255) begin : g_bad_stuck_frames
      $error("STUCK_FRAMES must be in 1..255");
   end

   logic [9:0] r_raw;
   logic       r_last_v;   // 0 = digit 8, 1 = digit 2
   logic       r_last_h;   // 0 = digit 6, 1 = digit 4
   logic [9:0] w_hit;
   logic [9:0] w_set;
   logic [9:0] w_clr;
   logic [9:0] w_timeout;
   logic [9:0] w_raw_next;
   logic [9:0] w_filt;

   // Full 9-bit compare, so extended (E0) codes never match.
   always_comb begin
      w_hit = 10'h000;
      case (keyCode)
         9'h070:  w_hit = 10'h001;
         9'h069:  w_hit = 10'h002;
         9'h072:  w_hit = 10'h004;
         9'h07A:  w_hit = 10'h008;
         9'h06B:  w_hit = 10'h010;
         9'h073:  w_hit = 10'h020;
         9'h074:  w_hit = 10'h040;
         9'h06C:  w_hit = 10'h080;
         9'h075:  w_hit = 10'h100;
         9'h07D:  w_hit = 10'h200;
         default: w_hit = 10'h000;
      endcase
   end

   assign w_set = make   ? w_hit : 10'h000;
   assign w_clr = brakee ? w_hit : 10'h000;

`ifdef KEY_STUCK_TIMEOUT_EN
   localparam logic [7:0] c_stuck_last = 8'(STUCK_FRAMES - 1);

   logic [7:0] r_cnt [10];
   logic [9:0] w_touch;

   assign w_touch = w_set | w_clr;

   always_comb begin
      w_timeout = 10'h000;
      for (int n = 0; n < 10; n++) begin
         w_timeout[n] = startOfFrame && r_raw[n] && !w_touch[n] &&
                        (r_cnt[n] == c_stuck_last);
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int n = 0; n < 10; n++) r_cnt[n] <= 8'd0;
      end else begin
         for (int n = 0; n < 10; n++) begin
            if (w_touch[n] || !r_raw[n])
               r_cnt[n] <= 8'd0;
            else if (startOfFrame)
               r_cnt[n] <= w_timeout[n] ? 8'd0 : r_cnt[n] + 8'd1;
         end
      end
   end
`else
   assign w_timeout = 10'h000;
`endif

   // Break beats make when both arrive together on the same code.
   assign w_raw_next = ((r_raw | w_set) & ~w_clr) & ~w_timeout;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_raw    <= 10'h000;
         r_last_v <= 1'b0;
         r_last_h <= 1'b0;
      end else begin
         r_raw <= w_raw_next;
         if (w_set[8])
            r_last_v <= 1'b0;
         else if (w_set[2])
            r_last_v <= 1'b1;
         if (w_set[6])
            r_last_h <= 1'b0;
         else if (w_set[4])
            r_last_h <= 1'b1;
      end
   end

   always_comb begin
      w_filt = r_raw;
      if (r_raw[8] && r_raw[2]) begin
         w_filt[8] = ~r_last_v;
         w_filt[2] =  r_last_v;
      end
      if (r_raw[6] && r_raw[4]) begin
         w_filt[6] = ~r_last_h;
         w_filt[4] =  r_last_h;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)
         num_input <= 10'h000;
      else if (startOfFrame)
         num_input <= game_over ? 10'h000 : w_filt;
   end

endmodule

`default_nettype wire

// File: tb/tb_keypad_direction_filter.sv
// ============================================================================
//  Module   : tb_keypad_direction_filter
//  Brief    : Directed scoreboard bench for keypad_direction_filter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_keypad_direction_filter;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       startOfFrame = 1'b0;
   logic [8:0] keyCode = 9'h000;
   logic       make = 1'b0;
   logic       brakee = 1'b0;
   logic       game_over = 1'b0;
   logic [9:0] num_input;

   int checks = 0;
   int errors = 0;
   logic [9:0] exp_q [$];

`ifdef KEY_STUCK_TIMEOUT_EN
   localparam bit c_timeout = 1'b1;
`else
   localparam bit c_timeout = 1'b0;
`endif

   keypad_direction_filter #(.STUCK_FRAMES(3)) dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .keyCode      (keyCode),
      .make         (make),
      .brakee       (brakee),
      .game_over    (game_over),
      .num_input    (num_input)
   );

   always #5 clk = ~clk;

   task automatic compare(input string tag);
      logic [9:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: scoreboard empty, num_input=%h", tag, num_input);
      end else begin
         e = exp_q.pop_front();
         checks++;
         assert (num_input === e) else begin
            errors++;
            $error("FAIL %s: num_input=%h expected=%h", tag, num_input, e);
         end
      end
   endtask

   task automatic cycle(input logic s, input logic [8:0] c, input logic m,
                        input logic b, input logic [9:0] e, input string tag);
      @(negedge clk);
      startOfFrame = s;
      keyCode = c;
      make = m;
      brakee = b;
      if (s) exp_q.push_back(e);
      @(negedge clk);
      startOfFrame = 1'b0;
      make = 1'b0;
      brakee = 1'b0;
      if (s) compare(tag);
   endtask

   task automatic key(input logic [8:0] c, input logic m, input logic b);
      cycle(1'b0, c, m, b, 10'h000, "");
   endtask

   task automatic sof(input logic [9:0] e, input string tag);
      cycle(1'b1, 9'h000, 1'b0, 1'b0, e, tag);
   endtask

   task automatic hold(input logic [9:0] e, input string tag);
      exp_q.push_back(e);
      compare(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetN = 1'b0;
      @(negedge clk);
      resetN = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      hold(10'h000, "reset_state");

      // single key
      key(9'h075, 1'b1, 1'b0);
      hold(10'h000, "pre_sof");
      sof(10'h100, "single_make");
      key(9'h075, 1'b0, 1'b1);
      hold(10'h100, "hold_mid_frame");
      sof(10'h000, "single_break");

      // opposing keys
      key(9'h075, 1'b1, 1'b0);
      key(9'h072, 1'b1, 1'b0);
      sof(10'h004, "vert_last_2");
      key(9'h072, 1'b0, 1'b1);
      sof(10'h100, "vert_loser_back");
      key(9'h072, 1'b1, 1'b0);
      sof(10'h004, "vert_2_again");
      key(9'h075, 1'b1, 1'b0);
      sof(10'h100, "vert_repeat_8");
      key(9'h074, 1'b1, 1'b0);
      key(9'h06B, 1'b1, 1'b0);
      sof(10'h110, "horiz_last_4");
      key(9'h06B, 1'b0, 1'b1);
      sof(10'h140, "horiz_loser_back");

      // mixed keys
      do_reset();
      key(9'h06B, 1'b1, 1'b0);
      key(9'h073, 1'b1, 1'b0);
      key(9'h074, 1'b1, 1'b0);
      sof(10'h060, "mixed_456");
      key(9'h175, 1'b1, 1'b0);
      sof(10'h060, "extended_make");
      key(9'h073, 1'b1, 1'b1);
      sof(10'h040, "make_brk_same");
      key(9'h174, 1'b0, 1'b1);
      sof(10'h040, "extended_break");
      cycle(1'b1, 9'h070, 1'b1, 1'b0, 10'h040, "make_with_sof");
      sof(10'h041, "make_next_frame");

      // game_over
      do_reset();
      key(9'h06B, 1'b1, 1'b0);
      game_over = 1'b1;
      sof(10'h000, "game_over_on");
      game_over = 1'b0;
      sof(10'h010, "game_over_off");

      // stuck key
      do_reset();
      key(9'h069, 1'b1, 1'b0);
      sof(10'h002, "stuck_sof1");
      sof(10'h002, "stuck_sof2");
      sof(10'h002, "stuck_sof3");
      sof(c_timeout ? 10'h000 : 10'h002, "stuck_sof4");
      sof(c_timeout ? 10'h000 : 10'h002, "stuck_sof5");

      do_reset();
      key(9'h069, 1'b1, 1'b0);
      sof(10'h002, "remake_sof1");
      sof(10'h002, "remake_sof2");
      key(9'h069, 1'b1, 1'b0);
      sof(10'h002, "remake_sof3");
      sof(10'h002, "remake_sof4");
      sof(10'h002, "remake_sof5");
      sof(c_timeout ? 10'h000 : 10'h002, "remake_sof6");

      // reset mid-frame
      do_reset();
      key(9'h074, 1'b1, 1'b0);
      sof(10'h040, "pre_reset");
      @(negedge clk);
      #2 resetN = 1'b0;
      #1 hold(10'h000, "async_reset");
      @(negedge clk);
      resetN = 1'b1;
      sof(10'h000, "post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
